// File: rtl/logic_switch_cfg_loader.sv
// Loads a logic_switch configuration frame word by word into a shadow register
// and commits it to prog atomically, so the switch matrix never sees a partial frame.
//
// state  | meaning
// IDLE   | prog stable, waiting for start
// LOAD   | accepting words into the shadow register
// COMMIT | copy shadow to prog, pulse done
module logic_switch_cfg_loader #(
  parameter int FRAME_W = 176,
  parameter int WORD_W  = 16,
  parameter int NWORDS  = 11
) (
  input  logic               clk,
  input  logic               nres,
  input  logic               start,
  input  logic               abort,
  input  logic               wr_valid,
  input  logic [WORD_W-1:0]  wr_data,
  output logic               wr_ready,
  output logic [FRAME_W-1:0] prog,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         word_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(NWORDS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [FRAME_W-1:0] shadow;
  logic               accept;

  assign accept = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)                                state_nxt = IDLE;
        else if (accept && word_cnt == LAST_CNT)  state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      LOAD: begin
        wr_ready = !abort;
        busy     = 1'b1;
      end
      COMMIT:  busy = 1'b1;
      default: ;
    endcase
  end

  // Word count stops at NWORDS because the last accepted word moves the FSM to COMMIT.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      shadow   <= '0;
      prog     <= '0;
      word_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shadow   <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            err <= 1'b1;
          end else if (accept) begin
            shadow   <= {shadow[FRAME_W-WORD_W-1:0], wr_data};
            word_cnt <= word_cnt + 4'd1;
          end
        end
        COMMIT: begin
          prog <= shadow;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
